// File: rtl/taylor_poly_inv.sv
// taylor_poly_inv
// Finds x in [X_LO, X_HI] with P(x) = sum c_k*x^k reaching a target y, by fixed-point
// bisection. Each probe P(mid) runs through a Horner loop on a single shared MAC, so
// one probe costs ORDER MAC cycles plus one bound-update cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a request, ready_in high
// S_EVAL   | Horner step per cycle: acc = ((acc*mid)>>>FB) + c_k, k counts down
// S_UPDATE | compare P(mid) against y, move lo or hi to mid, next probe or finish
// S_DONE   | result presented on x_out/clip_out until ready_out
module taylor_poly_inv #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ORDER      = 2,
    parameter int MAX_ORDER  = 7,
    parameter logic [(MAX_ORDER+1)*DATA_WIDTH-1:0] COEFFS =
        ((MAX_ORDER+1)*DATA_WIDTH)'(1) << (2*DATA_WIDTH + FRAC_BITS),
    parameter logic [DATA_WIDTH-1:0] X_LO = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] X_HI = 32'h0004_0000,
    parameter int ITERS      = 18,
    parameter int INCREASING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic                  clip_out
);

    localparam int DW = DATA_WIDTH;
    localparam int FB = FRAC_BITS;
    localparam int KW = (MAX_ORDER > 0) ? $clog2(MAX_ORDER + 1) : 1;
    localparam int IW = $clog2(ITERS + 1);

    localparam logic signed [DW-1:0] LO_S   = X_LO;
    localparam logic signed [DW-1:0] HI_S   = X_HI;
    localparam logic signed [DW-1:0] MID0_S = LO_S + ((HI_S - LO_S) >>> 1);
    localparam logic [KW-1:0]        K_TOP  = KW'(ORDER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DW-1:0] r_y;
    logic signed [DW-1:0] r_lo;
    logic signed [DW-1:0] r_hi;
    logic signed [DW-1:0] r_mid;
    logic signed [DW-1:0] r_acc;
    logic [KW-1:0]        r_k;
    logic [IW-1:0]        r_iter;
    logic [DW-1:0]        r_x_out;
    logic                 r_clip;

    // Coefficient slots unpacked from the COEFFS word, c0 in the low bits.
    logic signed [DW-1:0] w_coef [0:MAX_ORDER];

    genvar g;
    generate
        for (g = 0; g <= MAX_ORDER; g++) begin : g_coef
            assign w_coef[g] = COEFFS[g*DW +: DW];
        end
    endgenerate

    // Shared MAC: full-width signed product, floor shift by FB, keep the low DW bits.
    logic signed [2*DW-1:0] w_acc_ext;
    logic signed [2*DW-1:0] w_mid_ext;
    logic signed [2*DW-1:0] w_prod;
    logic signed [DW-1:0]   w_prod_q;
    logic signed [DW-1:0]   w_mac;
    logic                   w_unused_prod;

    assign w_acc_ext     = $signed({{DW{r_acc[DW-1]}}, r_acc});
    assign w_mid_ext     = $signed({{DW{r_mid[DW-1]}}, r_mid});
    assign w_prod        = w_acc_ext * w_mid_ext;
    // Bits [FB+DW-1:FB] of the product are exactly the low word of (prod >>> FB).
    assign w_prod_q      = $signed(w_prod[FB +: DW]);
    assign w_mac         = w_prod_q + w_coef[r_k];
    assign w_unused_prod = ^{w_prod[2*DW-1:FB+DW], w_prod[FB-1:0]};

    // Bisection decision and the bounds/midpoint for the next probe.
    logic                 w_go_up;
    logic signed [DW-1:0] w_lo_nxt;
    logic signed [DW-1:0] w_hi_nxt;
    logic signed [DW-1:0] w_mid_nxt;
    logic [IW-1:0]        w_iter_inc;
    logic                 w_last_iter;

    assign w_go_up     = (INCREASING != 0) ? (r_acc < r_y) : (r_acc > r_y);
    assign w_lo_nxt    = w_go_up ? r_mid : r_lo;
    assign w_hi_nxt    = w_go_up ? r_hi  : r_mid;
    assign w_mid_nxt   = w_lo_nxt + ((w_hi_nxt - w_lo_nxt) >>> 1);
    assign w_iter_inc  = r_iter + 1'b1;
    assign w_last_iter = (w_iter_inc == IW'(ITERS));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (valid_in) w_state_nxt = S_EVAL;
            S_EVAL:   if (r_k == '0) w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = w_last_iter ? S_DONE : S_EVAL;
            S_DONE:   if (ready_out) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Search datapath: request capture, Horner accumulation, bound updates, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_mid   <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_iter  <= '0;
            r_x_out <= '0;
            r_clip  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_y    <= y_in;
                        r_lo   <= LO_S;
                        r_hi   <= HI_S;
                        r_mid  <= MID0_S;
                        r_iter <= '0;
                        r_acc  <= w_coef[ORDER];
                        r_k    <= K_TOP;
                    end
                end
                S_EVAL: begin
                    r_acc <= w_mac;
                    if (r_k != '0) r_k <= r_k - 1'b1;
                end
                S_UPDATE: begin
                    r_lo   <= w_lo_nxt;
                    r_hi   <= w_hi_nxt;
                    r_iter <= w_iter_inc;
                    if (w_last_iter) begin
                        r_x_out <= (INCREASING != 0) ? w_hi_nxt : w_lo_nxt;
                        r_clip  <= (w_lo_nxt == LO_S) | (w_hi_nxt == HI_S);
                    end else begin
                        r_mid <= w_mid_nxt;
                        r_acc <= w_coef[ORDER];
                        r_k   <= K_TOP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_in  = (r_state == S_IDLE);
    assign valid_out = (r_state == S_DONE);
    assign x_out     = r_x_out;
    assign clip_out  = r_clip;

endmodule
